// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch prefetch unit.
package if_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'd100;
  localparam int          INSTR_W          = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  // One prefetched instruction together with the byte address it came from.
  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_unit_fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch_entry_t. Flush wins over push and pop.
module fetch_fifo
  import if_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output logic [PTR_W:0] count,
  output fetch_entry_t head
);

  fetch_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     count_q;
  logic               do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  assign do_pop  = pop  & ~flush & ~empty;
  assign do_push = push & ~flush & (~full | do_pop);

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values.
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage.
  // NOTE: the data array has no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/if_prefetch_unit.sv
// if_prefetch_unit: PC owner and instruction prefetcher feeding IF/ID.
// Optional macro IF_PREFETCH_STATS_EN adds stall_cycles / flushed_instrs counters.
module if_prefetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        id_ready
`ifdef IF_PREFETCH_STATS_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flushed_instrs
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OW    = $clog2(MAX_OUTSTANDING + 1);
  localparam int QW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [31:0]    fetch_pc_q, fetch_pc_d;
  logic [OW-1:0]  outst_q, outst_d;
  logic [OW-1:0]  drop_q, drop_d;
  logic [31:0]    pcq_q [MAX_OUTSTANDING];
  logic [QW-1:0]  pcq_wr_q, pcq_rd_q;

  logic           grant, rsp_ok, fifo_push, fifo_pop;
  logic           fifo_full, fifo_empty;
  logic [PTR_W:0] fifo_count;
  fetch_entry_t   fifo_head, rsp_entry;
  logic           unused_addr_lsbs;

  assign unused_addr_lsbs = ^redirect_pc[1:0];

  function automatic logic [QW-1:0] next_ptr(input logic [QW-1:0] p);
    return (p == QW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credit rule: never let buffered plus in-flight words exceed the FIFO.
  assign imem_req  = rst_n && (outst_q < OW'(MAX_OUTSTANDING))
                  && ((32'(fifo_count) + 32'(outst_q)) < 32'(DEPTH))
                  && !redirect_valid;
  assign imem_addr = fetch_pc_q;
  assign grant     = imem_req & imem_gnt;
  assign rsp_ok    = imem_rvalid & (outst_q != '0);

  assign rsp_entry = '{pc: pcq_q[pcq_rd_q], instr: imem_rdata};
  assign fifo_push = rsp_ok & (drop_q == '0);
  assign fifo_pop  = id_valid & id_ready;

  assign id_valid  = !fifo_empty;
  assign id_instr  = fifo_empty ? NOP_INSTR : fifo_head.instr;
  assign id_pc     = fifo_empty ? 32'd0     : fifo_head.pc;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (rsp_entry),
    .pop   (fifo_pop),
    .flush (redirect_valid),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (fifo_head)
  );

  // Next PC, outstanding credit and drop count; a redirect overrides the normal update.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    fetch_pc_d = fetch_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    case ({grant, rsp_ok})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: outst_d = outst_q;
    endcase
    if (grant)                  fetch_pc_d = fetch_pc_q + 32'd4;
    if (rsp_ok && drop_q != '0) drop_d     = drop_q - 1'b1;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      drop_d     = outst_d;
    end
  end

  // Fetch state registers and request-PC queue pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      pcq_wr_q   <= '0;
      pcq_rd_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      if (grant)  pcq_wr_q <= next_ptr(pcq_wr_q);
      if (rsp_ok) pcq_rd_q <= next_ptr(pcq_rd_q);
    end
  end

  // In-order record of issued addresses, paired with responses as they return.
  always_ff @(posedge clk) begin
    if (grant) pcq_q[pcq_wr_q] <= fetch_pc_q;
  end

`ifdef IF_PREFETCH_STATS_EN
  logic [31:0] stall_q, flushed_q;
  logic [32:0] stall_sum, flushed_sum;
  logic [31:0] flushed_inc;

  assign flushed_inc = (redirect_valid ? 32'(fifo_count) : 32'd0)
                     + ((rsp_ok && (drop_q != '0 || redirect_valid)) ? 32'd1 : 32'd0);
  assign stall_sum   = {1'b0, stall_q}   + {32'd0, (id_valid & ~id_ready)};
  assign flushed_sum = {1'b0, flushed_q} + {1'b0, flushed_inc};

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q   <= '0;
      flushed_q <= '0;
    end else begin
      stall_q   <= stall_sum[32]   ? '1 : stall_sum[31:0];
      flushed_q <= flushed_sum[32] ? '1 : flushed_sum[31:0];
    end
  end

  assign stall_cycles   = stall_q;
  assign flushed_instrs = flushed_q;
`endif

  // A response with nothing outstanding is a memory-side protocol violation.
  rvalid_has_credit: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> (outst_q != '0));

  // The credit rule must keep the FIFO from ever being pushed while full.
  no_fifo_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (fifo_push && !redirect_valid) |-> (!fifo_full || fifo_pop));

endmodule

// File: doc/if_prefetch_unit.md
Name: if_prefetch_unit

Overview:
- Instruction-fetch front end. Sits directly upstream of the IF/ID pipeline register and replaces the bare PC register plus adder.
- Owns the PC and issues word requests to instruction memory over a request/grant plus in-order response interface.
- Buffers returned instructions with their PCs in a small FIFO and presents them to IF/ID with a valid/ready handshake.
- A stall from decode backpressures the queue; a branch/jump redirect flushes it.

Parameters:
- RESET_PC, 32'd100, byte address of the first fetch after reset.
- DEPTH, 4, prefetch FIFO entries (power of two, at least 2).
- MAX_OUTSTANDING, 2, maximum granted requests still awaiting a response.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- redirect_valid  in  1  taken branch/jump from a later stage.
- redirect_pc  in  32  target byte address; bits [1:0] are ignored and forced to 0.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch byte address.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid; responses return in request order.
- imem_rdata  in  32  instruction word.
- id_valid  out  1  id_instr/id_pc hold a valid entry.
- id_instr  out  32  instruction to IF/ID.
- id_pc  out  32  PC of id_instr.
- id_ready  in  1  IF/ID accepts this cycle (low = stall).

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop=0, imem_req=0, imem_addr=RESET_PC, id_valid=0, id_instr=0, id_pc=0.
- Request issue:
  - imem_req=1 when outstanding < MAX_OUTSTANDING and (fifo_count + outstanding) < DEPTH and redirect_valid=0.
  - imem_addr=fetch_pc.
  - A grant is the cycle where imem_req & imem_gnt; on it, fetch_pc += 4 (32-bit wrap, 0xFFFFFFFC goes to 0) and outstanding increments.
  - While imem_req=1 and not granted, imem_addr is held stable.
- Request-PC tracking: a small in-order queue of issued PCs (MAX_OUTSTANDING entries) pairs each response with its address.
- Response handling:
  - On imem_rvalid, outstanding decrements.
  - If drop>0, the response is discarded and drop decrements.
  - Otherwise {pc, rdata} is pushed into the FIFO.
  - The credit rule guarantees the FIFO can never overflow. An rvalid with outstanding=0 is a protocol error: ignore it and fire an assertion.
- Output:
  - The FIFO head drives id_valid/id_instr/id_pc combinationally.
  - A pop occurs on id_valid & id_ready.
  - While id_ready=0, the head stays stable.
  - Latency: a grant at cycle N with rvalid at N+1 presents id_valid at N+2 when the FIFO was empty (the response is registered into the FIFO).
- Simultaneous events: push and pop in the same cycle leave the count unchanged. A grant and a response in the same cycle leave outstanding unchanged.
- Redirect (redirect_valid=1):
  - FIFO is cleared and id_valid is 0 from the next cycle.
  - drop = outstanding after this cycle's grant/response accounting.
  - fetch_pc = {redirect_pc[31:2],2'b00}.
  - No request is issued that cycle.
  - A redirect overrides a same-cycle pop.
  - A redirect while drop>0 accumulates correctly; drop never exceeds MAX_OUTSTANDING.
- Reset asserted mid-operation: everything returns to its reset values immediately. Responses still arriving after reset deasserts with outstanding=0 are ignored.

Optional Feature:
- Macro: IF_PREFETCH_STATS_EN.
- Defined:
  - Adds output stall_cycles[31:0], counting cycles with id_valid & !id_ready.
  - Adds output flushed_instrs[31:0], counting entries discarded by redirect (FIFO count + dropped responses).
  - Both are 32-bit saturating counters, cleared by rst_n.
- Not defined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package if_pkg:
  - RESET_PC_DEFAULT = 32'd100.
  - INSTR_W = 32.
  - NOP_INSTR = 32'h00000000.
  - Typedef fetch_entry_t {pc[31:0], instr[31:0]}.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t.
  - Parameter DEPTH.
  - Ports: push, pop, flush, full, empty, count, head.
  - Flush takes priority over push.

Test Plan:
- Reset with imem_gnt=1 and zero-wait rvalid: first imem_addr=100, then 104, 108. id_pc sequence 100, 104, 108 with matching rdata (e.g. 8C220000, 8C230004, 8C240008); id_valid first high 2 cycles after the first grant.
- Hold id_ready=0 for 10 cycles: exactly DEPTH=4 entries are fetched, then imem_req=0; id_instr stays stable; on release, entries 100..112 drain one per cycle in order.
- Redirect to 0x200 with 2 requests outstanding: both late responses are dropped; the next id_pc is 0x200; no stale PC (e.g. 108) ever appears on id_pc.
- Redirect to 0x203: imem_addr=0x200.
- imem_gnt held low for 5 cycles: imem_req stays 1 with imem_addr stable; fetch_pc does not advance.
- rst_n pulsed low mid-stream with 3 FIFO entries: id_valid drops asynchronously; after release imem_addr=100. With IF_PREFETCH_STATS_EN, the counters read 0.
